task_answer_packer: RTL

//  Back end for task wrappers: packs parallel task outputs into OUT_WIDTH answer words.

---
 rtl/task_answer_packer_pkg.sv | 24 ++
 rtl/task_answer_packer_if.sv | 40 ++++
 rtl/task_answer_packer_sync_fifo.sv | 51 +++++
 rtl/task_answer_packer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/task_answer_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : task_pkg
// Purpose  : Shared types and constants for the task answer packer.
// Revision : 1.0
// ============================================================================
package task_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } lat_state_t;

    localparam int MIN_FIFO_SIZE = 64;
    localparam int SIZE_W        = 32;

    // Index width that stays legal for a one-entry range.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/task_answer_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : task_answer_packer_if
// Purpose  : Task-side and answer-side signals of the answer packer.
// Revision : 1.0
// ============================================================================
interface task_answer_packer_if
    import task_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STREAMS    = 2,
    parameter int OUT_WIDTH  = 32,
    parameter int LAT_WIDTH  = 32
);
    logic                          i_in_valid;
    logic [STREAMS*DATA_WIDTH-1:0] i_data;
    logic                          i_valid;
    logic                          i_last;
    logic                          i_get_ready;
    logic [OUT_WIDTH-1:0]          o_data;
    logic [OUT_WIDTH/8-1:0]        o_keep;
    logic                          o_valid;
    logic                          i_ready;
    logic                          o_last;
    logic [SIZE_W-1:0]             o_size_bytes;
    logic [LAT_WIDTH-1:0]          o_latency;
    logic                          o_overflow;

    // master: the environment around the packer; slave: the packer itself
    modport master (
        output i_in_valid, i_data, i_valid, i_last, i_get_ready, i_ready,
        input  o_data, o_keep, o_valid, o_last, o_size_bytes, o_latency, o_overflow
    );

    modport slave (
        input  i_in_valid, i_data, i_valid, i_last, i_get_ready, i_ready,
        output o_data, o_keep, o_valid, o_last, o_size_bytes, o_latency, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/task_answer_packer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : task_sync_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with full/empty flags.
// Revision : 1.0
// ============================================================================
module task_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // A write into a full FIFO is dropped even if a read frees a slot this cycle.
    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/task_answer_packer.sv
`default_nettype none
// ============================================================================
// Module   : task_answer_packer
// Purpose  : Buffers parallel task beats, serialises lanes and packs answer words.
// Revision : 1.0
// ============================================================================
module task_answer_packer
    import task_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STREAMS    = 2,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = MIN_FIFO_SIZE,
    parameter int LAT_WIDTH  = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    task_answer_packer_if.slave bus
);
    localparam int K          = OUT_WIDTH / DATA_WIDTH;
    localparam int LANE_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_BYTES = STREAMS * DATA_WIDTH / 8;
    localparam int KEEP_W     = OUT_WIDTH / 8;
    localparam int SLOT_W     = safe_clog2(K);
    localparam int LANE_W     = safe_clog2(STREAMS);
    localparam int ENTRY_W    = STREAMS * DATA_WIDTH + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(STREAMS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(K - 1);

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_pop;
    logic [ENTRY_W-1:0] w_fifo_head;
    logic               w_beat_wr;

    assign w_beat_wr = bus.i_valid & ~w_fifo_full;

    task_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (bus.i_valid),
        .wr_data ({bus.i_last, bus.i_data}),
        .rd_en   (w_fifo_pop),
        .rd_data (w_fifo_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    logic [LANE_W-1:0]     r_lane_idx;
    logic [SLOT_W-1:0]     r_slot;
    logic [OUT_WIDTH-1:0]  r_acc_data;
    logic [KEEP_W-1:0]     r_acc_keep;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic [KEEP_W-1:0]     r_out_keep;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic                  w_lane_end;
    logic                  w_lane_last;
    logic                  w_word_done;
    logic                  w_out_free;
    logic                  w_lane_take;
    logic [OUT_WIDTH-1:0]  w_word;
    logic [KEEP_W-1:0]     w_keep;

    always_comb begin
        w_lane_data = '0;
        for (int s = 0; s < STREAMS; s++) begin
            if (r_lane_idx == LANE_W'(s)) w_lane_data = w_fifo_head[s*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_lane_end  = (r_lane_idx == LAST_LANE);
    assign w_lane_last = w_lane_end & w_fifo_head[ENTRY_W-1];
    assign w_word_done = w_lane_last | (r_slot == LAST_SLOT);
    assign w_out_free  = ~r_out_valid | bus.i_ready;
    // A lane that completes a word may only enter when the output register frees up.
    assign w_lane_take = ~w_fifo_empty & (~w_word_done | w_out_free);
    assign w_fifo_pop  = w_lane_take & w_lane_end;

    always_comb begin
        w_word = r_acc_data;
        w_keep = r_acc_keep;
        for (int k = 0; k < K; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_word[k*DATA_WIDTH +: DATA_WIDTH] = w_lane_data;
                w_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lane_idx  <= '0;
            r_slot      <= '0;
            r_acc_data  <= '0;
            r_acc_keep  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid & bus.i_ready) r_out_valid <= 1'b0;
            if (w_lane_take) begin
                r_lane_idx <= w_lane_end ? '0 : r_lane_idx + LANE_W'(1);
                if (w_word_done) begin
                    r_out_data  <= w_word;
                    r_out_keep  <= w_keep;
                    r_out_last  <= w_lane_last;
                    r_out_valid <= 1'b1;
                    r_acc_data  <= '0;
                    r_acc_keep  <= '0;
                    r_slot      <= '0;
                end else begin
                    r_acc_data <= w_word;
                    r_acc_keep <= w_keep;
                    r_slot     <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

    logic [SIZE_W-1:0] r_size;
    logic              r_size_done;
    logic              r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_size      <= '0;
            r_size_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (bus.i_valid & w_fifo_full) r_overflow <= 1'b1;
            if (bus.i_get_ready) begin
                r_size      <= w_beat_wr ? SIZE_W'(BEAT_BYTES) : '0;
                r_size_done <= w_beat_wr & bus.i_last;
            end else if (w_beat_wr & ~r_size_done) begin
                r_size      <= r_size + SIZE_W'(BEAT_BYTES);
                r_size_done <= bus.i_last;
            end
        end
    end

    lat_state_t           r_state;
    lat_state_t           w_state_next;
    logic [LAT_WIDTH-1:0] r_cnt;
    logic [LAT_WIDTH-1:0] w_cnt_next;
    logic [LAT_WIDTH-1:0] r_lat;
    logic [LAT_WIDTH-1:0] w_lat_next;
    logic [LAT_WIDTH-1:0] w_cnt_inc;

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + LAT_WIDTH'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lat   <= w_lat_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lat_next   = r_lat;
        case (r_state)
            IDLE: begin
                if (bus.i_in_valid) begin
                    w_cnt_next = '0;
                    if (bus.i_valid) begin
                        w_state_next = DONE;
                        w_lat_next   = '0;
                    end else begin
                        w_state_next = COUNT;
                    end
                end
            end
            COUNT: begin
                if (bus.i_get_ready) begin
                    w_state_next = IDLE;
                end else if (bus.i_valid) begin
                    w_state_next = DONE;
                    w_lat_next   = w_cnt_inc;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            DONE: begin
                if (bus.i_get_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.o_data       = r_out_data;
    assign bus.o_keep       = r_out_keep;
    assign bus.o_valid      = r_out_valid;
    assign bus.o_last       = r_out_last;
    assign bus.o_size_bytes = r_size;
    assign bus.o_latency    = r_lat;
    assign bus.o_overflow   = r_overflow;
endmodule
`default_nettype wire
